// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths and load funct3 encodings
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_ext.sv
// rtl/load_ext.sv - byte/halfword select and sign/zero extension of load data
module load_ext
    import riscv_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data,
    output logic            misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    // Unknown funct3 falls through as a full-word load but is flagged.
    always_comb begin
        data     = word;
        misalign = 1'b0;
        case (funct3)
            F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: data = {24'd0, byte_sel};
            F3_LH: begin
                data     = {{16{half_sel[15]}}, half_sel};
                misalign = addr_lo[0];
            end
            F3_LHU: begin
                data     = {16'd0, half_sel};
                misalign = addr_lo[0];
            end
            F3_LW:  misalign = (addr_lo != 2'b00);
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back arbitration of ALU and load results with load scoreboard
module wb_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_issue,
    input  logic [4:0]      ld_issue_rd,
    input  logic            ld_resp_valid,
    input  logic [4:0]      ld_resp_rd,
    input  logic [XLEN-1:0] ld_resp_data,
    input  logic [2:0]      ld_resp_funct3,
    input  logic [1:0]      ld_resp_addr_lo,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            stall,
    output logic            proto_err,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rd_data,
    output logic            reg_write
);

    logic            skid_full;
    logic [4:0]      skid_rd;
    logic [XLEN-1:0] skid_data;
    logic            out_is_load;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic [XLEN-1:0] ext_data;
    logic            ext_misalign;
    logic            alu_accept;
    logic            win_valid;
    logic            win_load;
    logic [4:0]      win_rd;
    logic [XLEN-1:0] win_data;
    logic            err_now;

    load_ext u_load_ext (
        .funct3   (ld_resp_funct3),
        .addr_lo  (ld_resp_addr_lo),
        .word     (ld_resp_data),
        .data     (ext_data),
        .misalign (ext_misalign)
    );

    assign alu_ready  = !skid_full;
    assign alu_accept = alu_valid && alu_ready;

    always_comb begin
        win_valid = 1'b0;
        win_load  = 1'b0;
        win_rd    = 5'd0;
        win_data  = '0;
        if (ld_resp_valid) begin
            win_valid = 1'b1;
            win_load  = 1'b1;
            win_rd    = ld_resp_rd;
            win_data  = ext_data;
        end else if (skid_full) begin
            win_valid = 1'b1;
            win_rd    = skid_rd;
            win_data  = skid_data;
        end else if (alu_accept) begin
            win_valid = 1'b1;
            win_rd    = alu_rd;
            win_data  = alu_data;
        end
    end

    // Clear lands on the same edge the register file captures the load; a new issue overrides it.
    always_comb begin
        busy_next = busy;
        if (reg_write && out_is_load)
            busy_next[rd] = 1'b0;
        if (ld_issue && (ld_issue_rd != 5'd0))
            busy_next[ld_issue_rd] = 1'b1;
    end

    assign err_now = (ld_issue && (ld_issue_rd != 5'd0) && busy[ld_issue_rd])
                   || (ld_resp_valid && (!busy[ld_resp_rd] || ext_misalign));

    assign stall = ((rs1 != 5'd0) && busy[rs1]) || ((rs2 != 5'd0) && busy[rs2]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write   <= 1'b0;
            rd          <= 5'd0;
            rd_data     <= '0;
            out_is_load <= 1'b0;
            skid_full   <= 1'b0;
            skid_rd     <= 5'd0;
            skid_data   <= '0;
            busy        <= '0;
            proto_err   <= 1'b0;
        end else begin
            reg_write   <= win_valid && (win_rd != 5'd0);
            rd          <= win_rd;
            rd_data     <= (win_rd != 5'd0) ? win_data : '0;
            out_is_load <= win_load;
            busy        <= busy_next;
            if (ld_resp_valid && alu_accept) begin
                skid_full <= 1'b1;
                skid_rd   <= alu_rd;
                skid_data <= alu_data;
            end else if (!ld_resp_valid) begin
                skid_full <= 1'b0;
            end
            if (err_now)
                proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - randomized and directed self-checking bench for wb_stage
module tb_wb_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        ld_resp_valid;
    logic [4:0]  ld_resp_rd;
    logic [31:0] ld_resp_data;
    logic [2:0]  ld_resp_funct3;
    logic [1:0]  ld_resp_addr_lo;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        stall;
    logic        proto_err;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        reg_write;

    wb_stage dut (
        .clk             (clk),
        .rst             (rst),
        .alu_valid       (alu_valid),
        .alu_ready       (alu_ready),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .ld_issue        (ld_issue),
        .ld_issue_rd     (ld_issue_rd),
        .ld_resp_valid   (ld_resp_valid),
        .ld_resp_rd      (ld_resp_rd),
        .ld_resp_data    (ld_resp_data),
        .ld_resp_funct3  (ld_resp_funct3),
        .ld_resp_addr_lo (ld_resp_addr_lo),
        .rs1             (rs1),
        .rs2             (rs2),
        .stall           (stall),
        .proto_err       (proto_err),
        .rd              (rd),
        .rd_data         (rd_data),
        .reg_write       (reg_write)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: pending ALU results in order, busy set, expected output register.
    logic [31:0] m_busy;
    logic [4:0]  q_rd[$];
    logic [31:0] q_data[$];
    bit          m_we;
    bit          m_x0;
    bit          m_is_load;
    bit          m_proto;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: begin
                v = (w >> (8 * a)) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                v = (w >> (16 * (a / 2))) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic bit ref_mis(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return (a % 2) != 0;
            3'd2:       return a != 0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic bit exp_stall();
        return ((rs1 != 0) && m_busy[rs1]) || ((rs2 != 0) && m_busy[rs2]);
    endfunction

    task automatic model_reset();
        m_busy = '0;
        q_rd.delete();
        q_data.delete();
        m_we = 0; m_x0 = 0; m_is_load = 0; m_proto = 0;
        m_rd = 0; m_data = 0;
    endtask

    task automatic model_edge();
        bit          have;
        bit          wload;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        if (rst) begin
            model_reset();
            return;
        end
        if (alu_valid && q_rd.size() == 0) begin
            q_rd.push_back(alu_rd);
            q_data.push_back(alu_data);
        end
        if (ld_issue && ld_issue_rd != 0 && m_busy[ld_issue_rd]) m_proto = 1;
        if (ld_resp_valid && (!m_busy[ld_resp_rd] || ref_mis(ld_resp_funct3, ld_resp_addr_lo))) m_proto = 1;
        if (m_we && m_is_load) m_busy[m_rd] = 1'b0;
        if (ld_issue && ld_issue_rd != 0) m_busy[ld_issue_rd] = 1'b1;
        have = 0; wload = 0; wrd = 0; wdata = 0;
        if (ld_resp_valid) begin
            have = 1; wload = 1; wrd = ld_resp_rd;
            wdata = ref_ext(ld_resp_funct3, ld_resp_addr_lo, ld_resp_data);
        end else if (q_rd.size() > 0) begin
            have = 1;
            wrd = q_rd.pop_front();
            wdata = q_data.pop_front();
        end
        m_we      = have && wrd != 0;
        m_x0      = have && wrd == 0;
        m_rd      = wrd;
        m_data    = (wrd != 0) ? wdata : 32'd0;
        m_is_load = wload;
    endtask

    task automatic compare();
        chk("reg_write", reg_write, m_we);
        if (m_we) begin
            chk("rd", rd, m_rd);
            chk("rd_data", rd_data, m_data);
        end
        if (m_x0) chk("x0_rd_data", rd_data, 32'd0);
        chk("alu_ready", alu_ready, q_rd.size() == 0);
        chk("proto_err", proto_err, m_proto);
    endtask

    // Inputs are set at a falling edge; one call covers one clock cycle.
    task automatic step();
        #1;
        chk("stall", stall, exp_stall());
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_issue = 0; ld_issue_rd = 0;
        ld_resp_valid = 0; ld_resp_rd = 0; ld_resp_data = 0;
        ld_resp_funct3 = 0; ld_resp_addr_lo = 0;
        rs1 = 0; rs2 = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        model_reset();
        idle();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_reg_write", reg_write, 32'd0);
        chk("rst_rd", rd, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_proto_err", proto_err, 32'd0);
        chk("rst_alu_ready", alu_ready, 32'd1);
        @(negedge clk);
    endtask

    task automatic issue(input logic [4:0] r);
        idle(); ld_issue = 1; ld_issue_rd = r; step();
    endtask

    logic [2:0] f3_tab[5];
    logic [4:0] ost[$];

    initial begin
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        rst = 1;
        idle();
        model_reset();
        @(negedge clk);
        do_reset();

        // Plain ALU write.
        idle(); alu_valid = 1; alu_rd = 5; alu_data = 32'h1234; step();
        chk("alu_we", reg_write, 1); chk("alu_rd", rd, 5);
        chk("alu_data", rd_data, 32'h1234); chk("alu_rdy", alu_ready, 1);

        // Load to x7: stall while pending, LB sign extension at byte 1.
        issue(7);
        idle(); rs1 = 7; #1; chk("stall_x7", stall, 1); step();
        idle(); rs1 = 7; ld_resp_valid = 1; ld_resp_rd = 7; ld_resp_funct3 = F3_LB;
        ld_resp_data = 32'h0000_8000; ld_resp_addr_lo = 1; step();
        chk("lb_we", reg_write, 1); chk("lb_rd", rd, 7); chk("lb_data", rd_data, 32'hFFFF_FF80);
        idle(); rs1 = 7; #1; chk("stall_x7_wr", stall, 1); step();
        idle(); rs1 = 7; #1; chk("stall_x7_done", stall, 0);

        // Load and ALU collide: load first, ALU next via skid.
        issue(3);
        idle(); ld_resp_valid = 1; ld_resp_rd = 3; ld_resp_funct3 = F3_LW; ld_resp_data = 32'h33;
        alu_valid = 1; alu_rd = 4; alu_data = 32'hAA; step();
        chk("col_rd", rd, 3); chk("col_data", rd_data, 32'h33); chk("col_rdy", alu_ready, 0);
        idle(); step();
        chk("skid_we", reg_write, 1); chk("skid_rd", rd, 4);
        chk("skid_data", rd_data, 32'hAA); chk("skid_rdy", alu_ready, 1);

        // x0 destinations.
        idle(); alu_valid = 1; alu_rd = 0; alu_data = 32'hDEAD; step();
        chk("x0_we", reg_write, 0); chk("x0_data", rd_data, 0);
        issue(0);
        idle(); #1; chk("x0_stall", stall, 0); step();

        // WAW issue and misaligned LW.
        issue(9);
        issue(9);
        chk("waw_err", proto_err, 1);
        idle(); step();
        chk("waw_hold", proto_err, 1);
        do_reset();
        issue(10);
        idle(); ld_resp_valid = 1; ld_resp_rd = 10; ld_resp_funct3 = F3_LW; ld_resp_addr_lo = 2; step();
        chk("lw_mis_err", proto_err, 1);
        do_reset();

        // Reset while the skid is full and x6 is busy.
        issue(6);
        issue(8);
        idle(); ld_resp_valid = 1; ld_resp_rd = 8; ld_resp_funct3 = F3_LW; ld_resp_data = 32'h88;
        alu_valid = 1; alu_rd = 11; alu_data = 32'h11; step();
        chk("pre_rst_rdy", alu_ready, 0); chk("pre_rst_we", reg_write, 1);
        idle(); rst = 1; #1;
        chk("mid_rst_we", reg_write, 0); chk("mid_rst_rd", rd, 0); chk("mid_rst_data", rd_data, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 0; rs1 = 6; #1;
        chk("post_rst_stall", stall, 0); chk("post_rst_rdy", alu_ready, 1);
        @(negedge clk);

        // Random legal traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            idle();
            alu_valid = ($urandom % 2) == 0;
            alu_rd    = 5'($urandom % 32);
            alu_data  = $urandom;
            rs1       = 5'($urandom % 32);
            rs2       = 5'($urandom % 32);
            if (ost.size() > 0 && ($urandom % 3) == 0) begin
                int idx;
                int fi;
                idx = $urandom_range(ost.size() - 1, 0);
                ld_resp_valid = 1;
                ld_resp_rd = ost[idx];
                ost.delete(idx);
                fi = $urandom_range(4, 0);
                ld_resp_funct3 = f3_tab[fi];
                ld_resp_data = $urandom;
                case (ld_resp_funct3)
                    3'd0, 3'd4: ld_resp_addr_lo = 2'($urandom % 4);
                    3'd1, 3'd5: ld_resp_addr_lo = 2'(($urandom % 2) * 2);
                    default:    ld_resp_addr_lo = 2'd0;
                endcase
            end
            if (($urandom % 3) == 0) begin
                logic [4:0] r;
                r = 5'($urandom_range(31, 1));
                if (!m_busy[r]) begin
                    ld_issue = 1;
                    ld_issue_rd = r;
                end
            end
            step();
            if (ld_issue) ost.push_back(ld_issue_rd);
        end

        idle();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage directly upstream of the 32x32 register file.
- Merges two result sources into the register file's single write port (rd / rd_data / reg_write):
  - single-cycle ALU results;
  - out-of-band load responses from data memory.
- Also extends (sign or zero) load data and keeps a load-pending scoreboard, so decode can stall reads of registers whose load has not landed.

Parameters:
- XLEN, 32, data width.
- NREG, 32, architectural register count; fixed at 32, since register indices are 5 bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- alu_valid  input  1  ALU result offered.
- alu_ready  output  1  stage can take an ALU result this cycle.
- alu_rd  input  5  ALU destination register.
- alu_data  input  32  ALU result.
- ld_issue  input  1  load issued to memory this cycle.
- ld_issue_rd  input  5  destination register of the issued load.
- ld_resp_valid  input  1  load data returning; always accepted, there is no ready.
- ld_resp_rd  input  5  load destination register.
- ld_resp_data  input  32  raw aligned memory word.
- ld_resp_funct3  input  3  load type: LB, LH, LW, LBU or LHU.
- ld_resp_addr_lo  input  2  byte offset of the load address.
- rs1, rs2  input  5  source registers being read by decode.
- stall  output  1  rs1 or rs2 has a pending load.
- proto_err  output  1  sticky protocol-violation flag.
- rd  output  5  register-file destination.
- rd_data  output  32  register-file write data.
- reg_write  output  1  register-file write enable.

Behaviour:
- Reset (asynchronous, active-high; also applies mid-operation):
  - reg_write=0, rd=0, rd_data=0, proto_err=0.
  - Skid buffer emptied; any held ALU result is dropped.
  - All busy bits cleared.
  - alu_ready=1 as soon as reset is released.
- Output registers: rd, rd_data and reg_write are registered. A result accepted in cycle N appears at the outputs in cycle N+1 and is written into the register file at the end of N+1.
- Arbitration (one write per cycle), priority order:
  1. ld_resp_valid;
  2. skid buffer, if full;
  3. new ALU result (alu_valid && alu_ready).
- Skid buffer (one entry):
  - alu_ready = !skid_full; this is a registered signal.
  - If an ALU result is accepted while a load response or a full skid wins arbitration, it is captured in the skid. This cannot happen when the skid is full, because alu_ready=0.
  - The skid drains in the first cycle with no ld_resp_valid.
  - A skid drain and a new ALU accept never occur in the same cycle, since alu_ready=0 while full.
- x0 handling:
  - A winner with destination 0 is consumed, but reg_write=0 that cycle and rd_data=0.
  - busy[0] is never set.
- Load extension, selected by ld_resp_addr_lo:
  - LB/LBU: byte ld_resp_data[8*addr_lo +: 8], sign- or zero-extended.
  - LH/LHU: halfword at addr_lo[1], sign- or zero-extended; addr_lo[0]=1 sets proto_err.
  - LW: full word; addr_lo!=0 sets proto_err.
  - Any other funct3 is treated as LW and sets proto_err.
- Scoreboard (32 busy bits):
  - ld_issue with ld_issue_rd!=0 sets busy[ld_issue_rd] at the clock edge.
  - busy[rd] clears at the end of the cycle in which reg_write=1 for a load result (output stage tagged as load). This is exactly the edge at which the register file captures the data.
  - If a set and a clear hit the same register on the same edge, the set wins.
  - ld_issue to a register that is already busy is a WAW violation: it sets proto_err, and the busy bit stays set.
  - ld_resp_valid for a register that is not busy also sets proto_err.
- stall = (rs1!=0 && busy[rs1]) || (rs2!=0 && busy[rs2]); combinational, no bypass.
- ALU-to-ALU hazards are not tracked here; they are handled by the execute forwarding network.
- proto_err holds at 1 until rst.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN;
  - F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101.
- One natural sub-module: load_ext. It is combinational: funct3, addr_lo and the word in; extended data and a misalign flag out.
- Scoreboard, skid and arbitration stay in wb_stage.

Test Plan:
- ALU result x5=0x1234, no load active -> cycle+1: reg_write=1, rd=5, rd_data=0x1234; alu_ready stays 1.
- ld_issue rd=7; next cycles rs1=7 -> stall=1. Then ld_resp LB, data=0x0000_8000, addr_lo=1 -> rd_data=0xFFFF_FF80, reg_write=1 for x7; stall drops to 0 the cycle after the write.
- ld_resp x3 and ALU x4=0xAA in the same cycle -> x3 written in N+1, x4 written in N+2; alu_ready=0 during N+1.
- ALU with rd=0 and data=0xDEAD -> reg_write stays 0; ld_issue rd=0 -> stall is never asserted for x0.
- ld_issue x9 twice with no response between -> proto_err=1 and held. LW with addr_lo=2 -> proto_err=1.
- Assert rst while the skid is full and x6 is busy -> outputs 0 immediately; after release, stall=0 for rs1=6 and alu_ready=1.
